jtag_tap_responder: RTL

- Target-side JTAG TAP that answers the probe's TCK/TMS/TDI/nTRST and drives TDO/RTCK back; the opposite end of the probe-side JTAG pin mux.
- Used as an on-board loopback target for self-test of the probe path, and as a reusable TAP for CPLD/FPGA images in the same design.
- All JTAG pins are oversampled on a single system clock, CLK; there is no logic clocked by TCK.

---
 rtl/jtag_tap_responder.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/jtag_tap_responder.sv
// jtag_tap_responder
//
// Target-side IEEE 1149.1 TAP controller. It answers a probe's
// TCK/TMS/TDI/nTRST and returns TDO and RTCK. All JTAG pins are
// oversampled on CLK, and no logic is clocked by TCK. CLK must run at
// least 6x faster than TCK.
//
// Ports:
//   CLK        system clock
//   RST        synchronous, active-high reset
//   TCK        JTAG clock from the probe (asynchronous)
//   TMS, TDI   JTAG mode select / data in (asynchronous)
//   nTRST      JTAG reset, active low (asynchronous)
//   TDO        JTAG data out
//   TDO_OE     high while TDO carries valid shift data
//   RTCK       synchronized TCK echo for adaptive clocking
//   TAP_STATE  current TAP state (4-bit encoding below)
//   IR         current instruction
//   USER_DATA  USER data register contents
//
// Optional feature macro: TAP_USER_DR_EN
//   When this macro is defined, opcode USER_IR selects an 8-bit USER data
//   register. When it is undefined, USER_IR falls back to BYPASS and
//   USER_DATA is tied to 8'h00.

module jtag_tap_responder #(
  parameter int                  IR_WIDTH  = 4,
  parameter logic [31:0]         IDCODE    = 32'h0BB1_0001,
  parameter logic [IR_WIDTH-1:0] IDCODE_IR = IR_WIDTH'(4'b0001),
  parameter logic [IR_WIDTH-1:0] USER_IR   = IR_WIDTH'(4'b1000)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                TCK,
  input  logic                TMS,
  input  logic                TDI,
  input  logic                nTRST,
  output logic                TDO,
  output logic                TDO_OE,
  output logic                RTCK,
  output logic [3:0]          TAP_STATE,
  output logic [IR_WIDTH-1:0] IR,
  output logic [7:0]          USER_DATA
);

  localparam logic [3:0] ST_EX2DR = 4'h0;
  localparam logic [3:0] ST_EX1DR = 4'h1;
  localparam logic [3:0] ST_SHDR  = 4'h2;
  localparam logic [3:0] ST_PDR   = 4'h3;
  localparam logic [3:0] ST_SELIR = 4'h4;
  localparam logic [3:0] ST_UPDR  = 4'h5;
  localparam logic [3:0] ST_CAPDR = 4'h6;
  localparam logic [3:0] ST_SELDR = 4'h7;
  localparam logic [3:0] ST_EX2IR = 4'h8;
  localparam logic [3:0] ST_EX1IR = 4'h9;
  localparam logic [3:0] ST_SHIR  = 4'hA;
  localparam logic [3:0] ST_PIR   = 4'hB;
  localparam logic [3:0] ST_RTI   = 4'hC;
  localparam logic [3:0] ST_UPIR  = 4'hD;
  localparam logic [3:0] ST_CAPIR = 4'hE;
  localparam logic [3:0] ST_TLR   = 4'hF;

  logic tck_m, tck_s, tck_d;
  logic tms_m, tms_s;
  logic tdi_m, tdi_s;
  logic trst_m, trst_s;
  logic rise, fall;

  logic [3:0]          state;
  logic [3:0]          next_state;
  logic [IR_WIDTH-1:0] ir_sr;
  logic [31:0]         dr_sr;
  logic                sel_idcode;
  logic                sel_user;

  // Two-flop synchronizers for every JTAG pin. TCK has a third flop for
  // edge detection. TMS and TDI are taken from the same stage as TCK, so
  // they line up with the detected edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      tck_m  <= 1'b0;
      tck_s  <= 1'b0;
      tck_d  <= 1'b0;
      tms_m  <= 1'b0;
      tms_s  <= 1'b0;
      tdi_m  <= 1'b0;
      tdi_s  <= 1'b0;
      trst_m <= 1'b0;
      trst_s <= 1'b0;
    end else begin
      tck_m  <= TCK;
      tck_s  <= tck_m;
      tck_d  <= tck_s;
      tms_m  <= TMS;
      tms_s  <= tms_m;
      tdi_m  <= TDI;
      tdi_s  <= tdi_m;
      trst_m <= nTRST;
      trst_s <= trst_m;
    end
  end

  assign rise      = tck_s & ~tck_d;
  assign fall      = ~tck_s & tck_d;
  assign RTCK      = tck_s;
  assign TAP_STATE = state;

  // Instruction decode. Any opcode that is not recognised selects BYPASS.
  assign sel_idcode = (IR == IDCODE_IR);
`ifdef TAP_USER_DR_EN
  assign sel_user   = (IR == USER_IR) && !sel_idcode;
`else
  // The USER opcode is decoded here but is always routed to BYPASS in
  // this build.
  assign sel_user   = (IR == USER_IR) & 1'b0;
`endif

  // Standard 1149.1 next-state table. TMS is sampled on a TCK rise.
  always_comb begin
    next_state = ST_TLR;
    case (state)
      ST_TLR:   next_state = tms_s ? ST_TLR   : ST_RTI;
      ST_RTI:   next_state = tms_s ? ST_SELDR : ST_RTI;
      ST_SELDR: next_state = tms_s ? ST_SELIR : ST_CAPDR;
      ST_CAPDR: next_state = tms_s ? ST_EX1DR : ST_SHDR;
      ST_SHDR:  next_state = tms_s ? ST_EX1DR : ST_SHDR;
      ST_EX1DR: next_state = tms_s ? ST_UPDR  : ST_PDR;
      ST_PDR:   next_state = tms_s ? ST_EX2DR : ST_PDR;
      ST_EX2DR: next_state = tms_s ? ST_UPDR  : ST_SHDR;
      ST_UPDR:  next_state = tms_s ? ST_SELDR : ST_RTI;
      ST_SELIR: next_state = tms_s ? ST_TLR   : ST_CAPIR;
      ST_CAPIR: next_state = tms_s ? ST_EX1IR : ST_SHIR;
      ST_SHIR:  next_state = tms_s ? ST_EX1IR : ST_SHIR;
      ST_EX1IR: next_state = tms_s ? ST_UPIR  : ST_PIR;
      ST_PIR:   next_state = tms_s ? ST_EX2IR : ST_PIR;
      ST_EX2IR: next_state = tms_s ? ST_UPIR  : ST_SHIR;
      ST_UPIR:  next_state = tms_s ? ST_SELDR : ST_RTI;
      default:  next_state = ST_TLR;
    endcase
  end

  // TAP core.
  //
  // The state advances on a TCK rise, and the capture/shift actions are
  // decided by the state before that transition. TDO and the IR update
  // on a TCK fall.
  //
  // While nTRST is low, the TAP is held in TLR and TCK edges are ignored.
  // TDO_OE is dropped at once so that a stale shift bit is not driven.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= ST_TLR;
      IR     <= IDCODE_IR;
      ir_sr  <= '0;
      dr_sr  <= '0;
      TDO    <= 1'b0;
      TDO_OE <= 1'b0;
    end else if (!trst_s) begin
      state  <= ST_TLR;
      IR     <= IDCODE_IR;
      TDO_OE <= 1'b0;
    end else if (rise) begin
      state <= next_state;
      case (state)
        ST_CAPIR: ir_sr <= IR_WIDTH'(2'b01);
        ST_SHIR:  ir_sr <= {tdi_s, ir_sr[IR_WIDTH-1:1]};
        ST_CAPDR: begin
          if (sel_idcode)
            dr_sr <= IDCODE;
          else if (sel_user)
            dr_sr <= {24'h0, USER_DATA};
          else
            dr_sr <= '0;
        end
        // TDI enters at the MSB of the selected register length:
        // 32 bits for IDCODE, 8 bits for USER, and 1 bit for BYPASS.
        ST_SHDR: begin
          if (sel_idcode)
            dr_sr <= {tdi_s, dr_sr[31:1]};
          else if (sel_user)
            dr_sr <= {dr_sr[31:8], tdi_s, dr_sr[7:1]};
          else
            dr_sr <= {dr_sr[31:1], tdi_s};
        end
        default: ;
      endcase
    end else if (fall) begin
      case (state)
        ST_UPIR: IR <= ir_sr;
        ST_TLR:  IR <= IDCODE_IR;
        default: ;
      endcase
      if (state == ST_SHIR) begin
        TDO    <= ir_sr[0];
        TDO_OE <= 1'b1;
      end else if (state == ST_SHDR) begin
        TDO    <= dr_sr[0];
        TDO_OE <= 1'b1;
      end else begin
        TDO_OE <= 1'b0;
      end
    end
  end

`ifdef TAP_USER_DR_EN
  // The USER register is written on the TCK fall in Update-DR, and only
  // while the USER instruction is selected.
  always_ff @(posedge CLK) begin
    if (RST)
      USER_DATA <= 8'h00;
    else if (trst_s && fall && (state == ST_UPDR) && sel_user)
      USER_DATA <= dr_sr[7:0];
  end
`else
  assign USER_DATA = 8'h00;
`endif

endmodule
